// File: rtl/tdm_pkg.sv
// Shared constants and types for the 8:1 time-division multiplexer.
// NUM_CH/CH_W describe the channel space; HOLD_MIN/HOLD_MAX bound the
// per-channel hold parameter; BEAT_W is wide enough for HOLD_MAX-1.
package tdm_pkg;
  localparam int unsigned NUM_CH   = 8;
  localparam int unsigned CH_W     = 3;
  localparam int unsigned HOLD_MIN = 1;
  localparam int unsigned HOLD_MAX = 16;
  localparam int unsigned BEAT_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tdm_state_e;
endpackage

// File: rtl/tdm_beat_counter.sv
// Beat/channel counter for the TDM multiplexer.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset (clears both counters)
//   en_i         advance one beat
//   clr_i        hold both counters at zero
//   ch_o         current channel (3 bits, wraps 7->0)
//   beat_o       current beat within the channel
//   last_beat_o  beat is HOLD_CYCLES-1
//   wrap_o       last beat of the last channel
module tdm_beat_counter
  import tdm_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  output logic [CH_W-1:0]   ch_o,
  output logic [BEAT_W-1:0] beat_o,
  output logic              last_beat_o,
  output logic              wrap_o
);

  // Out-of-range hold values are clamped into HOLD_MIN..HOLD_MAX.
  localparam int unsigned HOLD_EFF = (HOLD_CYCLES < HOLD_MIN) ? HOLD_MIN :
                                     (HOLD_CYCLES > HOLD_MAX) ? HOLD_MAX :
                                     HOLD_CYCLES;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(HOLD_EFF - 1);

  logic [CH_W-1:0]   ch_q, ch_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  always_comb begin
    last_beat_o = (beat_q == LAST_BEAT);
    wrap_o      = last_beat_o && (ch_q == '1);
    ch_o        = ch_q;
    beat_o      = beat_q;
  end

  always_comb begin
    ch_d   = ch_q;
    beat_d = beat_q;
    if (clr_i) begin
      ch_d   = '0;
      beat_d = '0;
    end else if (en_i) begin
      if (last_beat_o) begin
        beat_d = '0;
        ch_d   = ch_q + CH_W'(1);
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ch_q   <= '0;
      beat_q <= '0;
    end else begin
      ch_q   <= ch_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/tdm_mux_8to1.sv
// 8:1 time-division multiplexer: captures an 8-bit word on a ready/valid
// handshake and presents it serially as (i, s) pairs, channel 0 first,
// each channel held for HOLD_CYCLES clocks.
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   din          parallel word, bit k = channel k
//   load_valid   source offers din
//   load_ready   block accepts din this cycle
//   i            serial data (frame bit for channel s)
//   s            channel select paired with i
//   y_valid      i/s valid this cycle
//   frame_start  first cycle of channel 0
//   frame_end    last cycle of channel 7
module tdm_mux_8to1
  import tdm_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] din,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              i,
  output logic [CH_W-1:0]   s,
  output logic              y_valid,
  output logic              frame_start,
  output logic              frame_end
);

  tdm_state_e        state_q, state_d;
  logic [NUM_CH-1:0] frame_q, frame_d;
  logic [CH_W-1:0]   ch;
  logic [BEAT_W-1:0] beat;
  logic              last_beat;
  logic              wrap;
  logic              in_send;
  logic              handshake;

  tdm_beat_counter #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_beat_counter (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (in_send),
    .clr_i       (!in_send),
    .ch_o        (ch),
    .beat_o      (beat),
    .last_beat_o (last_beat),
    .wrap_o      (wrap)
  );

  // Outputs decode registered state only; din/load_valid reach state
  // registers but never an output.
  always_comb begin
    in_send     = (state_q == SEND);
    frame_start = in_send && (ch == '0) && (beat == '0);
    frame_end   = in_send && last_beat && (ch == CH_W'(NUM_CH - 1));
    load_ready  = !in_send || frame_end;
    y_valid     = in_send;
    s           = in_send ? ch : '0;
    i           = in_send ? frame_q[ch] : 1'b0;
    handshake   = load_valid && load_ready;
  end

  // The counter rolls to channel 0/beat 0 on its own at frame end, so a
  // handshake there continues straight into the next frame with no gap.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    if (handshake) begin
      frame_d = din;
    end
    unique case (state_q)
      IDLE: if (handshake) state_d = SEND;
      SEND: if (wrap)      state_d = handshake ? SEND : IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: tb/tb_tdm_mux_8to1.sv
module tb_tdm_mux_8to1;

  logic       clk;
  int         n_checks;
  int         n_fail;

  // HOLD_CYCLES = 1 instance
  logic       rst1, lv1, lr1, i1, yv1, fs1, fe1;
  logic [7:0] din1;
  logic [2:0] s1;
  // HOLD_CYCLES = 3 instance
  logic       rst3, lv3, lr3, i3, yv3, fs3, fe3;
  logic [7:0] din3;
  logic [2:0] s3;

  // Demultiplexer with one sampling register per output, fed by dut1.
  logic [7:0] lb_q;

  tdm_mux_8to1 #(.HOLD_CYCLES(1)) u_dut1 (
    .clk         (clk),
    .rst         (rst1),
    .din         (din1),
    .load_valid  (lv1),
    .load_ready  (lr1),
    .i           (i1),
    .s           (s1),
    .y_valid     (yv1),
    .frame_start (fs1),
    .frame_end   (fe1)
  );

  tdm_mux_8to1 #(.HOLD_CYCLES(3)) u_dut3 (
    .clk         (clk),
    .rst         (rst3),
    .din         (din3),
    .load_valid  (lv3),
    .load_ready  (lr3),
    .i           (i3),
    .s           (s3),
    .y_valid     (yv3),
    .frame_start (fs3),
    .frame_end   (fe3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst1) lb_q <= '0;
    else if (yv1) lb_q[s1] <= i1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {load_ready, y_valid, s, i, frame_start, frame_end} in IDLE = 8'h80
  task automatic idle1(input string tag);
    chk(tag, {lr1, yv1, s1, i1, fs1, fe1}, 8'h80);
  endtask

  task automatic idle3(input string tag);
    chk(tag, {lr3, yv3, s3, i3, fs3, fe3}, 8'h80);
  endtask

  // Load w on dut1 and check the 8 output cycles against exp_i (bit k = i at s=k).
  // Mid-frame load_valid and din changes must have no effect.
  task automatic send1(input string tag, input logic [7:0] w, input logic [7:0] exp_i);
    din1 = w;
    lv1  = 1'b1;
    step();
    lv1  = 1'b0;
    din1 = ~w;
    for (int k = 0; k < 8; k++) begin
      chk(tag, {yv1, s1, i1, fs1, fe1, lr1},
          {1'b1, 3'(k), exp_i[k], (k == 0), (k == 7), (k == 7)});
      if (k == 2) begin
        lv1  = 1'b1;
        din1 = 8'h3C;
      end
      if (k == 5) lv1 = 1'b0;
      if (k < 7) step();
    end
    step();
    idle1({tag, "_idle"});
  endtask

  task automatic send3(input string tag, input logic [7:0] w, input logic [7:0] exp_i);
    din3 = w;
    lv3  = 1'b1;
    step();
    lv3  = 1'b0;
    din3 = ~w;
    for (int k = 0; k < 24; k++) begin
      chk(tag, {yv3, s3, i3, fs3, fe3, lr3},
          {1'b1, 3'(k / 3), exp_i[k / 3], (k == 0), (k == 23), (k == 23)});
      if (k < 23) step();
    end
    step();
    idle3({tag, "_idle"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] b2b_exp;
    logic [7:0]  w;
    n_checks = 0;
    n_fail   = 0;
    rst1 = 1'b1; lv1 = 1'b0; din1 = '0;
    rst3 = 1'b1; lv3 = 1'b0; din3 = '0;

    // Reset held 3 cycles, then released with load_valid low.
    for (int k = 0; k < 3; k++) begin
      step();
      idle1("rst_hold1");
      idle3("rst_hold3");
    end
    rst1 = 1'b0;
    rst3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      idle1("post_rst1");
      idle3("post_rst3");
    end

    // HOLD=1, i sequence 1,0,1,0,0,1,0,1 for s=0..7.
    send1("h1_a5", 8'hA5, 8'hA5);
    send1("h1_3a", 8'h3A, 8'b0011_1010);

    // HOLD=3 frames.
    send3("h3_ff", 8'hFF, 8'hFF);
    send3("h3_96", 8'h96, 8'b1001_0110);

    // Back-to-back: 0F then F0 loaded during frame_end.
    // Bit k = expected i on contiguous cycle k.
    b2b_exp = 16'hF00F;
    din1 = 8'h0F;
    lv1  = 1'b1;
    step();
    lv1  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("b2b", {yv1, s1, i1, fs1, fe1, lr1},
          {1'b1, 3'(k % 8), b2b_exp[k], (k == 0 || k == 8),
           (k == 7 || k == 15), (k == 7 || k == 15)});
      if (k == 7) begin
        din1 = 8'hF0;
        lv1  = 1'b1;
      end
      if (k == 8) lv1 = 1'b0;
      if (k < 15) step();
    end
    step();
    idle1("b2b_idle");

    // Reset at s=4 aborts the frame; reset beats a simultaneous handshake.
    din1 = 8'h55;
    lv1  = 1'b1;
    step();
    lv1  = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("rst_at_s4", {yv1, s1}, {1'b1, 3'd4});
    rst1 = 1'b1;
    lv1  = 1'b1;
    din1 = 8'hFF;
    step();
    idle1("rst_abort");
    step();
    idle1("rst_override");
    rst1 = 1'b0;
    lv1  = 1'b0;
    step();
    idle1("rst_release");
    send1("after_rst", 8'h81, 8'b1000_0001);

    // Loopback through the sampled demultiplexer.
    for (int n = 0; n < 16; n++) begin
      w = 8'($urandom_range(0, 255));
      send1("lb_frame", w, w);
      chk("loopback", lb_q, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
